// File: rtl/dlatch_driver_if.sv
// rtl/dlatch_driver_if.sv - request handshake and latch-bank lines for dlatch_driver
interface dlatch_driver_if #(
  parameter int W = 1
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [W-1:0] D;
  logic         E;
  logic [W-1:0] Q;
  logic [W-1:0] nQ;
  logic         done;
  logic [W-1:0] err_mask;
  logic [7:0]   err_cnt;

  // master: requester plus latch bank; slave: the driver itself
  modport master (
    output in_valid, in_data, Q, nQ,
    input  in_ready, D, E, done, err_mask, err_cnt
  );

  modport slave (
    input  in_valid, in_data, Q, nQ,
    output in_ready, D, E, done, err_mask, err_cnt
  );
endinterface

// File: rtl/dlatch_driver.sv
// rtl/dlatch_driver.sv - timed setup/pulse/hold write sequencer for a D-latch bank with readback check
module dlatch_driver #(
  parameter int W         = 1,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic           clk,
  input  logic           rst,
  dlatch_driver_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    CHECK
  } state_t;

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

  state_t       state, state_nx;
  logic [3:0]   cnt, cnt_nx;
  logic [W-1:0] d_q, d_nx;
  logic         e_q, e_nx;
  logic         done_q, done_nx;
  logic [W-1:0] mask_q, mask_nx;
  logic [7:0]   err_cnt_q, err_cnt_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      d_q       <= '0;
      e_q       <= 1'b0;
      done_q    <= 1'b0;
      mask_q    <= '0;
      err_cnt_q <= 8'd0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      d_q       <= d_nx;
      e_q       <= e_nx;
      done_q    <= done_nx;
      mask_q    <= mask_nx;
      err_cnt_q <= err_cnt_nx;
    end
  end

  // E is computed one state ahead so the strobe leaves a flop, never a decoder
  always_comb begin
    state_nx   = state;
    cnt_nx     = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
    d_nx       = d_q;
    e_nx       = 1'b0;
    done_nx    = 1'b0;
    mask_nx    = mask_q;
    err_cnt_nx = err_cnt_q;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          d_nx     = bus.in_data;
          state_nx = SETUP;
          cnt_nx   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt == 4'd0) begin
          state_nx = PULSE;
          cnt_nx   = PULSE_LD;
          e_nx     = 1'b1;
        end
      end
      PULSE: begin
        if (cnt == 4'd0) begin
          state_nx = HOLD;
          cnt_nx   = HOLD_LD;
        end else begin
          e_nx = 1'b1;
        end
      end
      HOLD: begin
        if (cnt == 4'd0) begin
          state_nx = CHECK;
          cnt_nx   = 4'd0;
        end
      end
      CHECK: begin
        // a bit fails if it stored the wrong value or its outputs are not complementary
        mask_nx  = (bus.Q ^ d_q) | ~(bus.Q ^ bus.nQ);
        done_nx  = 1'b1;
        state_nx = IDLE;
        if ((|mask_nx) && (err_cnt_q != 8'hFF)) begin
          err_cnt_nx = err_cnt_q + 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.in_ready = (state == IDLE);
  assign bus.D        = d_q;
  assign bus.E        = e_q;
  assign bus.done     = done_q;
  assign bus.err_mask = mask_q;
  assign bus.err_cnt  = err_cnt_q;

endmodule
